// File: rtl/acc_requant_pipe.sv
// Requantizes 2-column signed 32-bit accumulator sums to int8 (ReLU, scale, rounding shift,
// zero-point, saturate) and buffers them in a first-word-fall-through FIFO toward the buffer writer.
module acc_requant_pipe #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [31:0]       in_col0,
  input  logic [31:0]       in_col1,
  input  logic              relu_en,
  input  logic [15:0]       scale,
  input  logic [4:0]        shift,
  input  logic [7:0]        zero_point,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_col0,
  output logic [7:0]        out_col1,
  output logic [CNT_W-1:0]  fifo_count,
  output logic              overflow,
  input  logic              clear_overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic               s1_valid_q, s1_valid_d;
  logic signed [31:0] s1_col0_q, s1_col0_d, s1_col1_q, s1_col1_d;
  logic               s1_relu_q, s1_relu_d;
  logic [15:0]        s1_scale_q, s1_scale_d;
  logic [4:0]         s1_shift_q, s1_shift_d;
  logic [7:0]         s1_zp_q, s1_zp_d;

  logic               s2_valid_q, s2_valid_d;
  logic signed [48:0] s2_p0_q, s2_p0_d, s2_p1_q, s2_p1_d;
  logic [4:0]         s2_shift_q, s2_shift_d;
  logic [7:0]         s2_zp_q, s2_zp_d;

  logic [15:0]        mem_q [FIFO_DEPTH];
  logic [15:0]        mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               overflow_q, overflow_d;

  logic               full, pop, push, drop;
  logic [7:0]         res0, res1;
  logic signed [31:0] x0, x1;
  logic signed [48:0] scale_ext;

  // Rounding shift (half-up), zero-point add and int8 saturation, done in 50 bits so nothing wraps.
  function automatic logic [7:0] requant(input logic signed [48:0] p,
                                         input logic [4:0] sh,
                                         input logic [7:0] zp);
    logic signed [49:0] rnd, sum, r, q;
    rnd = (sh == 5'd0) ? '0 : (50'sd1 <<< (sh - 5'd1));
    sum = $signed({p[48], p}) + rnd;
    r   = sum >>> sh;
    q   = r + $signed({{42{zp[7]}}, zp});
    if (q > 50'sd127)       requant = 8'h7f;
    else if (q < -50'sd128) requant = 8'h80;
    else                    requant = q[7:0];
  endfunction

  always_comb begin
    s1_valid_d = in_valid;
    s1_col0_d  = s1_col0_q;
    s1_col1_d  = s1_col1_q;
    s1_relu_d  = s1_relu_q;
    s1_scale_d = s1_scale_q;
    s1_shift_d = s1_shift_q;
    s1_zp_d    = s1_zp_q;
    if (in_valid) begin
      s1_col0_d  = in_col0;
      s1_col1_d  = in_col1;
      s1_relu_d  = relu_en;
      s1_scale_d = scale;
      s1_shift_d = shift;
      s1_zp_d    = zero_point;
    end
  end

  // The 49-bit product is exact: |x| < 2^31 and scale < 2^16.
  always_comb begin
    x0         = (s1_relu_q && s1_col0_q[31]) ? '0 : s1_col0_q;
    x1         = (s1_relu_q && s1_col1_q[31]) ? '0 : s1_col1_q;
    scale_ext  = $signed({33'd0, s1_scale_q});
    s2_valid_d = s1_valid_q;
    s2_p0_d    = s2_p0_q;
    s2_p1_d    = s2_p1_q;
    s2_shift_d = s2_shift_q;
    s2_zp_d    = s2_zp_q;
    if (s1_valid_q) begin
      s2_p0_d    = $signed({{17{x0[31]}}, x0}) * scale_ext;
      s2_p1_d    = $signed({{17{x1[31]}}, x1}) * scale_ext;
      s2_shift_d = s1_shift_q;
      s2_zp_d    = s1_zp_q;
    end
  end

  // A pop in the same cycle frees the slot, so a push into a full FIFO is only dropped without one.
  always_comb begin
    res0       = requant(s2_p0_q, s2_shift_q, s2_zp_q);
    res1       = requant(s2_p1_q, s2_shift_q, s2_zp_q);
    full       = (count_q == CNT_W'(FIFO_DEPTH));
    pop        = out_valid && out_ready;
    push       = s2_valid_q && (!full || pop);
    drop       = s2_valid_q && full && !pop;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = {res1, res0};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);
    if (drop)                overflow_d = 1'b1;
    else if (clear_overflow) overflow_d = 1'b0;
    else                     overflow_d = overflow_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Datapath and storage need no reset; the valids and count gate everything they hold.
  always_ff @(posedge clk) begin
    s1_col0_q  <= s1_col0_d;
    s1_col1_q  <= s1_col1_d;
    s1_relu_q  <= s1_relu_d;
    s1_scale_q <= s1_scale_d;
    s1_shift_q <= s1_shift_d;
    s1_zp_q    <= s1_zp_d;
    s2_p0_q    <= s2_p0_d;
    s2_p1_q    <= s2_p1_d;
    s2_shift_q <= s2_shift_d;
    s2_zp_q    <= s2_zp_d;
    mem_q      <= mem_d;
  end

  assign out_valid  = (count_q != '0);
  assign out_col0   = out_valid ? mem_q[rd_ptr_q][7:0]  : 8'd0;
  assign out_col1   = out_valid ? mem_q[rd_ptr_q][15:8] : 8'd0;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;

endmodule

// File: doc/acc_requant_pipe.md
Name: acc_requant_pipe

Overview:
- Downstream consumer of the 2-column accumulator memory.
- Takes the pair of signed 32-bit accumulated sums and applies optional ReLU, then a fixed-point multiply by scale.
- Then applies a rounding arithmetic right shift, adds a zero-point offset, and saturates to signed int8.
- The accumulator has no backpressure, so results land in a small output FIFO with a valid/ready handshake toward the unified buffer writer.

Parameters:
FIFO_DEPTH, 4, number of output entries (power of 2, >=2); each entry holds one col0/col1 int8 pair.
CNT_W, $clog2(FIFO_DEPTH)+1, width of fifo_count.

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high
in_valid  input  1  accumulator result valid (driven by accumulator valid_out)
in_col0  input  32  signed accumulated sum, column 0
in_col1  input  32  signed accumulated sum, column 1
relu_en  input  1  1: clamp negative sums to 0 before scaling
scale  input  16  unsigned multiplier
shift  input  5  right-shift amount 0..31
zero_point  input  8  signed output offset
out_valid  output  1  FIFO head valid
out_ready  input  1  consumer accepts head
out_col0  output  8  signed int8 result, column 0
out_col1  output  8  signed int8 result, column 1
fifo_count  output  CNT_W  occupied entries
overflow  output  1  sticky: a result was dropped because the FIFO was full
clear_overflow  input  1  clears overflow

Behaviour:
- Reset (synchronous, active-high; clock clk):
  - All pipeline valids, FIFO pointers, fifo_count and overflow go to 0.
  - out_valid=0, out_col0=out_col1=0.
  - Reset mid-stream discards in-flight beats and stored entries. First in_valid after reset deasserts is processed normally.
- relu_en, scale, shift and zero_point are sampled into stage S1 alongside the data. Config changes never corrupt beats already in flight.
- Pipeline:
  - S1 (edge ending cycle N): register in_col0/1 and config when in_valid=1. S1 valid = in_valid, with no stall.
  - S2 (edge ending N+1): x = (relu_en && v<0) ? 0 : v. Product p = x * {1'b0,scale}, 49-bit signed, exact, no truncation.
  - S3 (combinational in N+2, written into FIFO at edge ending N+2):
    - r = (shift==0) ? p : (p + (1<<(shift-1))) >>> shift. Arithmetic shift, round-half-up toward +inf.
    - q = r + sign-extended zero_point, computed in 50 bits.
    - Saturate q to [-128, 127].
- Latency: in_valid in cycle N, so out_valid rises in cycle N+3 if the FIFO was empty. Throughput is one beat per cycle.
- FIFO:
  - First-word-fall-through. out_col0/1 show the head entry whenever out_valid=1, and read 0 when the FIFO is empty.
  - Pop occurs on out_valid && out_ready. Ordering is strict FIFO.
  - Push occurs when S3 is valid. Push into an empty FIFO is visible the next cycle (no combinational bypass).
  - Simultaneous push and pop: count unchanged. This is legal even when full, because the pop frees the slot and the push is accepted.
  - Push when full without a pop: beat dropped, overflow set next cycle, FIFO contents and count unchanged.
  - Pop when empty: ignored.
  - Pointers wrap modulo FIFO_DEPTH. fifo_count ranges 0..FIFO_DEPTH.
- overflow:
  - Set on a drop; cleared by clear_overflow on the next edge.
  - If a drop and clear_overflow occur in the same cycle, set wins.
- out_col0/1 and out_valid are driven from registers and FIFO storage only. There is no combinational path from in_* or out_ready to any output.

Test Plan:
- Passthrough: scale=1, shift=0, zp=0, relu_en=0, out_ready=1. Drive in=(100,-5) in cycle 0 -> out_valid in cycle 3 with (100,-5), fifo_count then returns to 0.
- Saturation: scale=1, shift=0. Drive in=(1000,-1000) -> (127,-128). Then scale=3, shift=2, in=(200,0) -> (600+2)>>2=150 -> (127,0).
- Rounding: scale=1, shift=1, zp=0. Drive in=(3,-3) -> (2,-1). Then in=(1,-1) -> (1,0).
- ReLU and zero-point:
  - relu_en=1, zp=10, scale=1, shift=0, in=(-50,20) -> (10,30).
  - relu_en=0 with the same input -> (-40,30).
  - Config is changed the cycle after in_valid; the result must still use the old config.
- Backpressure/overflow: out_ready=0, 6 consecutive beats of (k,k) for k=1..6 -> fifo_count=4, overflow=1, beats 5 and 6 dropped. Then out_ready=1 drains (1,1)..(4,4) in order. clear_overflow -> overflow=0. A same-cycle drop plus clear keeps overflow=1.
- Full push+pop and reset:
  - FIFO full with out_ready=1 while a beat arrives -> count stays 4, no overflow, new beat appears last.
  - Reset asserted with 2 beats in flight and 3 stored -> next cycle out_valid=0, count=0, overflow=0, and no stale beat ever emerges.
